// File: rtl/reg_desp_param_if.sv
// rtl/reg_desp_param_if.sv - control/data bundle for the parametrised universal shift register
interface reg_desp_param_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
);
  logic             ENB;
  logic             DIR;
  logic [1:0]       MODO;
  logic             S_IN;
  logic [WIDTH-1:0] D;
  logic [CNT_W-1:0] N_SHIFT;
  logic             START;
  logic [WIDTH-1:0] Q;
  logic             S_OUT;
  logic             BUSY;
  logic             DONE;

  modport master (
    output ENB, DIR, MODO, S_IN, D, N_SHIFT, START,
    input  Q, S_OUT, BUSY, DONE
  );

  modport slave (
    input  ENB, DIR, MODO, S_IN, D, N_SHIFT, START,
    output Q, S_OUT, BUSY, DONE
  );
endinterface

// File: rtl/reg_desp_param.sv
// rtl/reg_desp_param.sv - universal shift register with arithmetic mode and N-step burst engine
module reg_desp_param #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             CLK,
  input  logic             RST_N,
  reg_desp_param_if.slave  bus
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             s_out_q, s_out_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       mode_q, mode_d;
  logic             dir_q, dir_d;
  logic             done_q, done_d;

  logic [1:0]       op_mode;
  logic             op_dir;
  logic [WIDTH-1:0] op_q;
  logic             op_s;
  logic             burst_go;

  // A running burst uses the mode/direction captured at START; otherwise the live inputs.
  always_comb begin
    op_mode = (state_q == RUN) ? mode_q : bus.MODO;
    op_dir  = (state_q == RUN) ? dir_q  : bus.DIR;
    op_q    = q_q;
    op_s    = 1'b0;
    case (op_mode)
      2'b00: begin
        if (op_dir) begin
          op_q = {q_q[WIDTH-2:0], bus.S_IN};
          op_s = q_q[WIDTH-1];
        end else begin
          op_q = {bus.S_IN, q_q[WIDTH-1:1]};
          op_s = q_q[0];
        end
      end
      2'b01: begin
        if (op_dir) begin
          op_q = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
          op_s = q_q[WIDTH-1];
        end else begin
          op_q = {q_q[0], q_q[WIDTH-1:1]};
          op_s = q_q[0];
        end
      end
      2'b10: begin
        op_q = bus.D;
        op_s = 1'b0;
      end
      default: begin
        if (op_dir) begin
          op_q = {q_q[WIDTH-2:0], 1'b0};
          op_s = q_q[WIDTH-1];
        end else begin
          op_q = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
          op_s = q_q[0];
        end
      end
    endcase
  end

  // Only multi-step shift/rotate bursts ever enter RUN; zero-length and load bursts finish in IDLE.
  assign burst_go = bus.ENB && bus.START && (bus.N_SHIFT != '0) &&
                    (bus.N_SHIFT != CNT_ONE) && (bus.MODO != 2'b10);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      q_q     <= '0;
      s_out_q <= 1'b0;
      count_q <= '0;
      mode_q  <= 2'b00;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      s_out_q <= s_out_d;
      count_q <= count_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (burst_go) state_d = RUN;
      RUN:     if (bus.ENB && (count_q == CNT_ONE)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    q_d     = q_q;
    s_out_d = s_out_q;
    count_d = count_q;
    mode_d  = mode_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    if (bus.ENB) begin
      if (state_q == RUN) begin
        q_d     = op_q;
        s_out_d = op_s;
        count_d = count_q - CNT_ONE;
        done_d  = (count_q == CNT_ONE);
      end else if (bus.START) begin
        mode_d  = bus.MODO;
        dir_d   = bus.DIR;
        count_d = bus.N_SHIFT;
        if (bus.N_SHIFT == '0) begin
          done_d = 1'b1;
        end else if (bus.MODO == 2'b10) begin
          q_d     = op_q;
          s_out_d = op_s;
          done_d  = 1'b1;
        end else begin
          q_d     = op_q;
          s_out_d = op_s;
          count_d = bus.N_SHIFT - CNT_ONE;
          done_d  = (bus.N_SHIFT == CNT_ONE);
        end
      end else begin
        q_d     = op_q;
        s_out_d = op_s;
      end
    end
  end

  always_comb begin
    bus.Q     = q_q;
    bus.S_OUT = s_out_q;
    bus.BUSY  = (state_q == RUN);
    bus.DONE  = done_q;
  end

endmodule

// File: tb/tb_reg_desp_param.sv
// tb/tb_reg_desp_param.sv - randomized + directed bench for reg_desp_param at WIDTH=8, CNT_W=4
module tb_reg_desp_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   errors = 0;

  reg_desp_param_if #(.WIDTH(8), .CNT_W(4)) bus();

  reg_desp_param #(.WIDTH(8), .CNT_W(4)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_q(logic [1:0] m, logic d, logic s, logic [7:0] q, logic [7:0] din);
    case (m)
      2'd0:    return d ? ((q << 1) | {7'd0, s}) : ((q >> 1) | ({7'd0, s} << 7));
      2'd1:    return d ? ((q << 1) | (q >> 7)) : ((q >> 1) | (q << 7));
      2'd2:    return din;
      default: return d ? (q << 1) : 8'($signed(q) >>> 1);
    endcase
  endfunction

  function automatic logic ref_s(logic [1:0] m, logic d, logic [7:0] q);
    if (m == 2'd2) return 1'b0;
    return d ? q[7] : q[0];
  endfunction

  logic [7:0] m_q;
  logic       m_s, m_busy, m_done, m_dir;
  logic [1:0] m_mode;
  int         m_rem;

  // Reference: a burst is "m_rem more operations still owed", nothing more.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q <= 8'h00; m_s <= 1'b0; m_busy <= 1'b0; m_done <= 1'b0;
      m_rem <= 0; m_mode <= 2'd0; m_dir <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (bus.ENB) begin
        if (m_busy) begin
          m_q   <= ref_q(m_mode, m_dir, bus.S_IN, m_q, bus.D);
          m_s   <= ref_s(m_mode, m_dir, m_q);
          m_rem <= m_rem - 1;
          if (m_rem == 1) begin
            m_busy <= 1'b0;
            m_done <= 1'b1;
          end
        end else if (bus.START) begin
          if (bus.N_SHIFT == 0) begin
            m_done <= 1'b1;
          end else begin
            m_q <= ref_q(bus.MODO, bus.DIR, bus.S_IN, m_q, bus.D);
            m_s <= ref_s(bus.MODO, bus.DIR, m_q);
            if (bus.MODO == 2'd2 || bus.N_SHIFT == 1) begin
              m_done <= 1'b1;
            end else begin
              m_busy <= 1'b1;
              m_rem  <= int'(bus.N_SHIFT) - 1;
              m_mode <= bus.MODO;
              m_dir  <= bus.DIR;
            end
          end
        end else begin
          m_q <= ref_q(bus.MODO, bus.DIR, bus.S_IN, m_q, bus.D);
          m_s <= ref_s(bus.MODO, bus.DIR, m_q);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      vectors++;
      if (bus.Q !== m_q || bus.S_OUT !== m_s || bus.BUSY !== m_busy || bus.DONE !== m_done) begin
        errors++;
        $display("FAIL model_cmp t=%0t actual Q=%h S_OUT=%b BUSY=%b DONE=%b required Q=%h S_OUT=%b BUSY=%b DONE=%b",
                 $time, bus.Q, bus.S_OUT, bus.BUSY, bus.DONE, m_q, m_s, m_busy, m_done);
      end
    end
  end

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(logic enb, logic start, logic [1:0] mode, logic dir, logic s_in, logic [7:0] d, logic [3:0] n);
    bus.ENB = enb; bus.START = start; bus.MODO = mode; bus.DIR = dir;
    bus.S_IN = s_in; bus.D = d; bus.N_SHIFT = n;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(string name, int budget, output int cycles);
    cycles = 0;
    while (bus.DONE !== 1'b1 && cycles < budget) begin
      cyc();
      cycles++;
      bus.START = 1'b0;
    end
    if (bus.DONE !== 1'b1) begin
      errors++;
      vectors++;
      $display("FAIL %s_timeout actual=no DONE required=DONE within %0d cycles", name, budget);
    end
  endtask

  int n_cyc;

  initial begin
    drive(0, 0, 2'd0, 0, 0, 8'h00, 4'd0);
    #2;
    chk("reset_q", bus.Q, 8'h00);
    chk("reset_flags", {5'd0, bus.S_OUT, bus.BUSY, bus.DONE}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Legacy single-step path
    drive(1, 0, 2'd2, 0, 0, 8'h96, 4'd0); cyc();
    chk("legacy_load", bus.Q, 8'h96);
    drive(1, 0, 2'd1, 1, 0, 8'h00, 4'd0); cyc();
    chk("legacy_rotl_q", bus.Q, 8'h2D);
    chk("legacy_rotl_s", {7'd0, bus.S_OUT}, 8'h01);
    drive(1, 0, 2'd0, 0, 1, 8'h00, 4'd0); cyc();
    chk("legacy_shr_q", bus.Q, 8'h96);
    chk("legacy_shr_s", {7'd0, bus.S_OUT}, 8'h01);

    // Arithmetic right burst of 3 from 0x90
    drive(1, 0, 2'd2, 0, 0, 8'h90, 4'd0); cyc();
    drive(1, 1, 2'd3, 0, 1, 8'h00, 4'd3); cyc();
    chk("asr_busy1", {7'd0, bus.BUSY}, 8'h01);
    bus.START = 1'b0; cyc();
    chk("asr_busy2", {7'd0, bus.BUSY}, 8'h01);
    cyc();
    chk("asr_q", bus.Q, 8'hF2);
    chk("asr_end_flags", {5'd0, bus.S_OUT, bus.BUSY, bus.DONE}, 8'h01);
    bus.ENB = 1'b0; cyc();
    chk("asr_done_pulse", {7'd0, bus.DONE}, 8'h00);

    // Rotate right by 9 with a 2-cycle stall and stray START/MODO during RUN
    drive(1, 0, 2'd2, 0, 0, 8'h81, 4'd0); cyc();
    drive(1, 1, 2'd1, 0, 0, 8'h00, 4'd9); cyc();
    n_cyc = 1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 2'd2, 1, 1, 8'h55, 4'd2); cyc(); n_cyc++;
    end
    bus.ENB = 1'b0; cyc(); cyc(); n_cyc += 2;
    bus.ENB = 1'b1;
    while (bus.DONE !== 1'b1 && n_cyc < 20) begin
      cyc(); n_cyc++;
    end
    bus.START = 1'b0;
    chk("rot_q", bus.Q, 8'hC0);
    chk("rot_cycles", 8'(n_cyc), 8'd11);

    // Zero-length burst
    drive(1, 1, 2'd1, 1, 0, 8'h00, 4'd0); cyc();
    chk("n0_q", bus.Q, 8'hC0);
    chk("n0_flags", {6'd0, bus.BUSY, bus.DONE}, 8'h01);

    // Load via START
    drive(1, 1, 2'd2, 0, 0, 8'h3C, 4'd5); cyc();
    chk("start_load_q", bus.Q, 8'h3C);
    chk("start_load_flags", {6'd0, bus.BUSY, bus.DONE}, 8'h01);

    // Logical left by 15 saturates to zero
    drive(1, 0, 2'd2, 0, 0, 8'hFF, 4'd0); cyc();
    drive(1, 1, 2'd0, 1, 0, 8'h00, 4'd15);
    wait_done("shl15", 20, n_cyc);
    chk("shl15_q", bus.Q, 8'h00);
    chk("shl15_cycles", 8'(n_cyc), 8'd15);

    // Asynchronous reset mid-burst
    drive(1, 0, 2'd2, 0, 0, 8'hA5, 4'd0); cyc();
    drive(1, 1, 2'd1, 1, 0, 8'h00, 4'd10); cyc();
    bus.START = 1'b0; cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_q", bus.Q, 8'h00);
    chk("async_rst_flags", {6'd0, bus.BUSY, bus.DONE}, 8'h00);
    bus.ENB = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    chk("post_rst_done", {6'd0, bus.BUSY, bus.DONE}, 8'h00);

    // Randomized mix of legacy ops, bursts and stalls
    for (int i = 0; i < 600; i++) begin
      drive(($urandom % 5) != 0, ($urandom % 6) == 0, 2'($urandom), 1'($urandom),
            1'($urandom), 8'($urandom), 4'($urandom));
      cyc();
    end

    bus.ENB = 1'b0;
    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
